// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Covers the FSM state type, the funct3 codes, legality, byte enables and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legality of a single-direction access; the rd&wr collision is checked by the caller.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_wr,
                                    input logic [1:0] off);
    logic ok;
    unique case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_wr;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !is_wr && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    unique case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Store data is replicated across lanes so the byte enables alone select the target bytes.
  function automatic logic [31:0] wr_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] w;
    unique case (f3[1:0])
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    unique case (f3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   res = {24'd0, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised data RAM: byte-enable synchronous write, registered synchronous read.
// The array carries no reset so it maps onto plain memory macros.
module dmem_sram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_comb begin
    rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: aligned loads/stores with wait states and a pipeline stall.
// Optional DMEM_TRACE_EN adds trc_* access-trace outputs, valid in the DONE cycle only.
//
// state | meaning
// IDLE  | waiting for a request; stall follows req_rd|req_wr combinationally
// BUSY  | wait states counting down; access happens at the edge leaving count 0
// DONE  | one-cycle response (rsp_valid); inputs ignored, always back to IDLE
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata
`ifdef DMEM_TRACE_EN
  ,
  output logic              trc_wr,
  output logic              trc_rd,
  output logic [ADDR_W-1:0] trc_addr,
  output logic [DATA_W-1:0] trc_wdata,
  output logic [DATA_W-1:0] trc_rdata
`endif
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic        ld_q, ld_d;
  logic [2:0]  acc_f3_q, acc_f3_d;
  logic [1:0]  acc_off_q, acc_off_d;

  logic        req_any;
  logic        req_ok;
  logic        stall_c;
  logic        access_fire;
  logic [1:0]  off;
  logic [3:0]  ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] load_val;

  assign off     = req_addr[1:0];
  assign req_any = req_rd | req_wr;
  assign req_ok  = (req_rd ^ req_wr) && f3_legal(req_funct3, req_wr, off);

  // The IDLE request cycle is the first stall cycle, so BUSY lasts WAIT_CYC cycles in total.
  assign access_fire = ((state_q == IDLE) && req_ok && (WAIT_LD == 4'd0)) ||
                       ((state_q == BUSY) && (cnt_q == 4'd0));

  assign ram_be    = byte_en(req_funct3, off);
  assign ram_wdata = wr_lanes(req_funct3, req_wdata);

  dmem_sram #(
    .AW (ADDR_W - 2),
    .DW (DATA_W)
  ) u_sram (
    .clk   (clk),
    .wr_en (access_fire & req_wr),
    .addr  (req_addr[ADDR_W-1:2]),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read launched at the access edge is extended during DONE and then held.
  assign load_val = load_ext(acc_f3_q, acc_off_q, ram_rdata);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ld_d        = 1'b0;
    acc_f3_d    = acc_f3_q;
    acc_off_d   = acc_off_q;
    stall_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_c = req_any;
        if (req_any) begin
          if (!req_ok) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (WAIT_LD == 4'd0) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_LD - 4'd1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (ld_q) rsp_rdata_d = load_val;
      end
      default: state_d = IDLE;
    endcase
    if (access_fire) begin
      ld_d      = req_rd;
      acc_f3_d  = req_funct3;
      acc_off_d = off;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ld_q        <= 1'b0;
      acc_f3_q    <= 3'd0;
      acc_off_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ld_q        <= ld_d;
      acc_f3_q    <= acc_f3_d;
      acc_off_q   <= acc_off_d;
    end
  end

  // Reset also masks the combinational stall so a held request cannot leak through.
  assign stall     = stall_c & ~reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = ld_q ? load_val : rsp_rdata_q;

`ifdef DMEM_TRACE_EN
  logic              trc_wr_q, trc_wr_d;
  logic              trc_rd_q, trc_rd_d;
  logic [ADDR_W-1:0] trc_addr_q, trc_addr_d;
  logic [DATA_W-1:0] trc_wdata_q, trc_wdata_d;

  always_comb begin
    trc_wr_d    = 1'b0;
    trc_rd_d    = 1'b0;
    trc_addr_d  = '0;
    trc_wdata_d = '0;
    if (access_fire) begin
      trc_wr_d   = req_wr;
      trc_rd_d   = req_rd;
      trc_addr_d = req_addr;
      if (req_wr) trc_wdata_d = ram_wdata & be_mask(ram_be);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trc_wr_q    <= 1'b0;
      trc_rd_q    <= 1'b0;
      trc_addr_q  <= '0;
      trc_wdata_q <= '0;
    end else begin
      trc_wr_q    <= trc_wr_d;
      trc_rd_q    <= trc_rd_d;
      trc_addr_q  <= trc_addr_d;
      trc_wdata_q <= trc_wdata_d;
    end
  end

  assign trc_wr    = trc_wr_q;
  assign trc_rd    = trc_rd_q;
  assign trc_addr  = trc_addr_q;
  assign trc_wdata = trc_wdata_q;
  assign trc_rdata = trc_rd_q ? load_val : '0;
`endif

endmodule
